sha256_kw_sequencer: RTL and testbench
======================================

SHA256_KW_SEQUENCER -- requirements
Module: sha256_kw_sequencer

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit words, 6-bit round index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a block; sampled only in IDLE.
REQ-005 block_in  input  512  message block; W0 = block_in[511:480], W15 = block_in[31:0]; sampled with accepted start.
REQ-006 k_addr  output  6  round-constant ROM address, combinational.
REQ-007 k_ena  output  1  ROM enable, combinational; ROM registers K[k_addr] at the edge where k_ena=1.
REQ-008 k_in  input  32  ROM data, valid one cycle after k_ena=1, held while k_ena=0.
REQ-009 kw_out  output  32  K[t] + W[t] mod 2^32, registered.
REQ-010 kw_round  output  6  round index t of kw_out, registered.
REQ-011 kw_valid  output  1  kw_out/kw_round valid.
REQ-012 kw_ready  input  1  downstream accepts the beat when kw_valid && kw_ready.
REQ-013 busy  output  1  high from the cycle after accepted start until the cycle after done.
REQ-014 done  output  1  one-cycle pulse coincident with acceptance of the round-63 beat.

Function
REQ-015 States IDLE, RUN, DRAIN; round counter t (6 bit); 16x32 schedule window w[0..15], w[0] = W[t].
REQ-016 IDLE: k_addr=0, k_ena=start; start=1 loads w[i]=W_i from block_in, t=0, next state RUN.
REQ-017 advance = !kw_valid || kw_ready (output slot free at this edge).
REQ-018 RUN: k_addr=t+1, k_ena = advance && (t != 63).
REQ-019 RUN with advance: kw_out<=k_in+w[0], kw_round<=t, kw_valid<=1, w[i]<=w[i+1] (i=0..14), w[15]<=new word, t<=t+1.
REQ-020 new word = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0] mod 2^32.
REQ-021 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-022 RUN without advance: t, w, kw_out, kw_round held; k_ena=0 so ROM holds K[t].
REQ-023 RUN advancing with t=63: next state DRAIN; t does not wrap into further rounds.
REQ-024 DRAIN: k_ena=0; when kw_valid && kw_ready, assert done, kw_valid<=0, next state IDLE.
REQ-025 Beats not in DRAIN: kw_valid cleared when accepted and no new beat is loaded (not reachable in RUN, since advance always reloads).
REQ-026 Once asserted, kw_valid SHALL NOT drop and kw_out/kw_round SHALL NOT change until accepted.
REQ-027 Exactly 64 beats per block, rounds 0..63 in order, no skip or duplicate under any kw_ready pattern.
REQ-028 Latency: with kw_ready=1, round-0 beat valid 2 cycles after start, one beat per cycle thereafter.
REQ-029 start outside IDLE ignored, including start in the same cycle as done; start one cycle later is accepted.
REQ-030 k_ena=0 in all states except as defined in REQ-016/REQ-018.

Reset
REQ-031 rst=0 at an edge: state IDLE, t=0, w all 0, kw_out=0, kw_round=0, kw_valid=0, busy=0, done=0.
REQ-032 Reset mid-block aborts with no further beats; outputs follow REQ-031 the next cycle; a subsequent start runs a full block.
REQ-033 While rst=0, k_ena=0 and start is ignored.

Verification
REQ-034 "abc" block (W0=0x61626380, W15=0x00000018, others 0), kw_ready=1 -> round0 0xA3EC9318, round1 0x71374491, round15 0xC19BF18C, round16 0x45FDCD41.
REQ-035 All-zero block, kw_ready=1, start at cycle 0 -> kw_out=K[t] in cycles 2..65, done=1 in cycle 65, busy=0 in cycle 67.
REQ-036 kw_ready=0 for 5 cycles while round 10 is presented -> kw_out/kw_round stable, k_ena=0, round 11 follows on release.
REQ-037 Random kw_ready toggling -> 64 beats, rounds 0..63 in order, values match a reference model.
REQ-038 start pulsed mid-RUN and in the done cycle -> ignored; start the cycle after done -> new block, round0 2 cycles later.
REQ-039 rst=0 at round 30 -> next cycle all outputs 0 and IDLE; restart reproduces REQ-034 values.

Source files
------------

// File: rtl/sha256_kw_sequencer.sv
// Streams K[t] + W[t] for the 64 SHA-256 rounds of one 512-bit block; first beat 2 cycles after start, then 1/cycle.
// kw_valid/kw_ready backpressure: a stalled beat holds output, schedule and ROM address until it is accepted.
module sha256_kw_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic [5:0]   k_addr,
  output logic         k_ena,
  input  logic [31:0]  k_in,
  output logic [31:0]  kw_out,
  output logic [5:0]   kw_round,
  output logic         kw_valid,
  input  logic         kw_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  t;
  logic [31:0] w [16];
  logic [31:0] w_new;
  logic        done_q;
  logic        advance;
  logic        load;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // The output slot is free when empty or being drained this edge.
  assign advance = !kw_valid || kw_ready;
  assign w_new   = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
  // Stretched one cycle past done so busy covers the cycle after the last beat.
  assign busy    = (state != IDLE) || done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_addr    = 6'd0;
    k_ena     = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        k_ena = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // Prefetch K[t+1] only when the current beat moves; otherwise the ROM keeps K[t].
        k_addr = t + 6'd1;
        k_ena  = advance && (t != 6'd63);
        load   = advance;
        if (advance && (t == 6'd63)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (kw_valid && kw_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      k_ena = 1'b0;
      load  = 1'b0;
      done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      t        <= 6'd0;
      kw_out   <= 32'd0;
      kw_round <= 6'd0;
      kw_valid <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= 32'd0;
    end else begin
      done_q <= done;
      if ((state == IDLE) && start) begin
        t <= 6'd0;
        for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
      end else if (load) begin
        kw_out   <= k_in + w[0];
        kw_round <= t;
        kw_valid <= 1'b1;
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
        if (t != 6'd63) t <= t + 6'd1;
      end else if (kw_valid && kw_ready) begin
        kw_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_kw_sequencer.sv
// Self-checking bench for sha256_kw_sequencer: ROM model, full-schedule reference, directed and random ready patterns.
module tb_sha256_kw_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [5:0]   k_addr;
  logic         k_ena;
  logic [31:0]  k_in = 32'd0;
  logic [31:0]  kw_out;
  logic [5:0]   kw_round;
  logic         kw_valid;
  logic         kw_ready;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  sha256_kw_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .block_in(block_in),
    .k_addr(k_addr), .k_ena(k_ena), .k_in(k_in),
    .kw_out(kw_out), .kw_round(kw_round), .kw_valid(kw_valid), .kw_ready(kw_ready),
    .busy(busy), .done(done)
  );

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Registered ROM: data for k_addr appears the cycle after k_ena, held otherwise.
  always @(posedge clk) if (k_ena) k_in <= KTAB[k_addr];

  typedef struct {
    int          round;
    logic [31:0] abc_kw;
    logic [31:0] zero_kw;
  } vec_t;

  vec_t        vecs [4];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_kw [64];
  logic [31:0] cap [64];
  logic [31:0] cap_abc [64];
  logic [31:0] cap_zero [64];
  int          beat_idx;
  bit          hold_pending;
  logic [31:0] held_out;
  logic [5:0]  held_round;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole 64-word schedule computed up front, then K added per round.
  task automatic begin_block(input logic [511:0] blk);
    logic [31:0] wm [64];
    for (int i = 0; i < 16; i++) wm[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      wm[i] = (ror(wm[i-2], 17) ^ ror(wm[i-2], 19) ^ (wm[i-2] >> 10)) + wm[i-7]
            + (ror(wm[i-15], 7) ^ ror(wm[i-15], 18) ^ (wm[i-15] >> 3)) + wm[i-16];
    for (int i = 0; i < 64; i++) exp_kw[i] = KTAB[i] + wm[i];
    block_in = blk;
    beat_idx = 0;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // One clock cycle: drive at negedge, sample just after, scoreboard accepted beats.
  task automatic cyc(input bit s, input bit r, input bit rs);
    bit acc;
    @(negedge clk);
    start = s; kw_ready = r; rst = rs;
    #1;
    if (hold_pending)
      chk("hold", 64'({kw_valid, kw_round, kw_out}), 64'({1'b1, held_round, held_out}));
    acc = kw_valid && kw_ready && rs;
    chk("done", 64'(done), 64'(acc && (beat_idx == 63)));
    if (acc) begin
      if (beat_idx >= 64) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: round %0d presented after 64 beats", kw_round);
      end else begin
        chk($sformatf("round_%0d", beat_idx), 64'(kw_round), 64'(beat_idx));
        chk($sformatf("kw_%0d", beat_idx), 64'(kw_out), 64'(exp_kw[beat_idx]));
        cap[beat_idx] = kw_out;
        beat_idx++;
      end
    end
    hold_pending = kw_valid && !kw_ready && rs;
    held_out     = kw_out;
    held_round   = kw_round;
    if (!rs) begin
      beat_idx     = 64;
      hold_pending = 0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc;
    int first_valid, done_cyc, c;
    logic busy1, busy66, busy67;

    vecs[0] = '{0,  32'hA3EC9318, 32'h428A2F98};
    vecs[1] = '{1,  32'h71374491, 32'h71374491};
    vecs[2] = '{15, 32'hC19BF18C, 32'hC19BF174};
    vecs[3] = '{16, 32'h45FDCD41, 32'hE49B69C1};
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    start = 0; kw_ready = 0; rst = 0; block_in = '0;
    beat_idx = 64; hold_pending = 0;

    // Reset held with start high: no ROM access, everything cleared.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0);
      chk("rst_k_ena", 64'(k_ena), 64'(0));
    end
    chk("rst_kw_out", 64'(kw_out), 64'(0));
    chk("rst_kw_round", 64'(kw_round), 64'(0));
    chk("rst_kw_valid", 64'(kw_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1);
      chk("post_rst_valid", 64'(kw_valid), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
    end

    // "abc" block, always ready.
    begin_block(abc);
    for (int i = 0; i < 70; i++) cyc(i == 0, 1, 1);
    chk("abc_beats", 64'(beat_idx), 64'(64));
    cap_abc = cap;

    // All-zero block: latency, done and busy timing.
    begin_block('0);
    first_valid = -1; done_cyc = -1; busy1 = 0; busy66 = 1; busy67 = 1;
    for (int i = 0; i < 68; i++) begin
      cyc(i == 0, 1, 1);
      if (kw_valid && first_valid < 0) first_valid = i;
      if (done) done_cyc = i;
      if (i == 1)  busy1 = busy;
      if (i == 66) busy66 = busy;
      if (i == 67) busy67 = busy;
    end
    cap_zero = cap;
    chk("first_valid_cycle", 64'(first_valid), 64'(2));
    chk("done_cycle", 64'(done_cyc), 64'(65));
    chk("busy_cycle1", 64'(busy1), 64'(1));
    chk("busy_cycle66", 64'(busy66), 64'(1));
    chk("busy_cycle67", 64'(busy67), 64'(0));
    chk("zero_beats", 64'(beat_idx), 64'(64));

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("vec_abc_r%0d", vecs[i].round), 64'(cap_abc[vecs[i].round]), 64'(vecs[i].abc_kw));
      chk($sformatf("vec_zero_r%0d", vecs[i].round), 64'(cap_zero[vecs[i].round]), 64'(vecs[i].zero_kw));
    end

    // Stall 5 cycles while round 10 is presented.
    begin_block(rand_block());
    for (int i = 0; i < 76; i++) begin
      cyc(i == 0, !(i >= 12 && i <= 16), 1);
      if (i >= 12 && i <= 16) begin
        chk("stall_round", 64'(kw_round), 64'(10));
        chk("stall_k_ena", 64'(k_ena), 64'(0));
      end
      if (i == 18) chk("after_stall_round", 64'({kw_valid, kw_round}), 64'({1'b1, 6'd11}));
    end
    chk("stall_beats", 64'(beat_idx), 64'(64));

    // Random backpressure on random blocks.
    for (int b = 0; b < 4; b++) begin
      begin_block(rand_block());
      for (c = 0; c < 1500; c++) begin
        cyc(c == 0, ($urandom_range(0, 2) != 0), 1);
        if (c > 1 && !busy) break;
      end
      chk($sformatf("random_beats_%0d", b), 64'(beat_idx), 64'(64));
    end

    // Start mid-run and in the done cycle ignored; start the next cycle accepted.
    begin_block(rand_block());
    for (int i = 0; i < 137; i++) begin
      if (i == 20 || i == 65) block_in = rand_block();
      if (i == 66) begin
        chk("blk1_beats", 64'(beat_idx), 64'(64));
        begin_block(rand_block());
      end
      cyc(i == 0 || i == 20 || i == 65 || i == 66, 1, 1);
      if (i == 65) chk("done_with_start", 64'(done), 64'(1));
      if (i == 68) chk("restart_round0", 64'({kw_valid, kw_round}), 64'({1'b1, 6'd0}));
    end
    chk("blk2_beats", 64'(beat_idx), 64'(64));

    // Reset while round 30 is presented, then rerun "abc".
    begin_block(abc);
    for (int i = 0; i < 40; i++) begin
      cyc(i == 0, 1, i != 32);
      if (i == 33) begin
        chk("abort_kw_out", 64'(kw_out), 64'(0));
        chk("abort_kw_round", 64'(kw_round), 64'(0));
        chk("abort_kw_valid", 64'(kw_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_k_ena", 64'(k_ena), 64'(0));
      end
      if (i == 38) chk("abort_idle_valid", 64'(kw_valid), 64'(0));
    end
    begin_block(abc);
    for (int i = 0; i < 70; i++) cyc(i == 0, 1, 1);
    chk("rerun_beats", 64'(beat_idx), 64'(64));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rerun_abc_r%0d", vecs[i].round), 64'(cap[vecs[i].round]), 64'(vecs[i].abc_kw));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
